// File: rtl/addsub_serial.sv
// rtl/addsub_serial.sv - chunk-serial add/subtract with valid/ready handshakes and flags
// Optional signed saturation of the result is enabled by defining ADDSUB_SAT_EN.
module addsub_serial #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             mode_q;
  logic             carry_q;
  logic [IDXW-1:0]  idx_q;
  logic [WIDTH-1:0] res_q;

  logic [CHUNK:0]   chunk_add;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] final_sum;
  logic             last_chunk;
  logic             raw_ovf;

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign last_chunk = (idx_q == IDXW'(NCHUNK - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = CALC;
      CALC:    if (last_chunk) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // b_q already holds ~b for subtraction, so one overflow rule covers both modes
  always_comb begin
    chunk_add = {1'b0, a_q[idx_q*CHUNK +: CHUNK]}
              + {1'b0, b_q[idx_q*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_q};
    res_next = res_q;
    res_next[idx_q*CHUNK +: CHUNK] = chunk_add[CHUNK-1:0];
    raw_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_next[WIDTH-1] != a_q[WIDTH-1]);
`ifdef ADDSUB_SAT_EN
    if (raw_ovf)
      final_sum = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      final_sum = res_next;
`else
    final_sum = res_next;
`endif
  end

  // Outputs live in their own registers so they hold steady while CALC rebuilds res_q
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= 1'b0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      res_q     <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q     <= a;
          b_q     <= mode ? ~b : b;
          mode_q  <= mode;
          carry_q <= mode;
          idx_q   <= '0;
          res_q   <= '0;
        end
        CALC: begin
          res_q   <= res_next;
          carry_q <= chunk_add[CHUNK];
          idx_q   <= idx_q + 1'b1;
          if (last_chunk) begin
            sum       <= final_sum;
            carry_out <= mode_q ^ chunk_add[CHUNK];
            overflow  <= raw_ovf;
            zero      <= (final_sum == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// tb/tb_addsub_serial.sv - table-driven self-checking bench for addsub_serial
module tb_addsub_serial;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        carry_out;
  logic        overflow;
  logic        zero;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  addsub_serial #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .overflow(overflow), .zero(zero)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        mode;
    logic [15:0] s;
    logic        c;
    logic        ov;
    logic        z;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the acceptance edge
  task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tm);
    a = ta; b = tb_v; mode = tm; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; mode = ~tm;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  int lat;
  int seen;
  logic [15:0] prev_sum;

  initial begin
    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
`ifdef ADDSUB_SAT_EN
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
`else
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
`endif

    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 16'h0000);
    chk("rst_flags", {carry_out, overflow, zero}, 3'b000);
    reset = 1'b0;
    @(negedge clk);

    prev_sum = 16'h0000;
    for (int i = 0; i < 7; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].mode);
      chk($sformatf("v%0d_calc_in_ready", i), in_ready, 0);
      chk($sformatf("v%0d_calc_sum_held", i), sum, prev_sum);
      wait_done(lat);
      chk($sformatf("v%0d_latency", i), lat, 4);
      chk($sformatf("v%0d_sum", i), sum, vecs[i].s);
      chk($sformatf("v%0d_carry", i), carry_out, vecs[i].c);
      chk($sformatf("v%0d_ovf", i), overflow, vecs[i].ov);
      chk($sformatf("v%0d_zero", i), zero, vecs[i].z);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk($sformatf("v%0d_idle", i), {out_valid, in_ready}, 2'b01);
      prev_sum = vecs[i].s;
    end

    // Backpressure with a stray in_valid pulse while DONE
    start_op(16'h1111, 16'h2222, 1'b0);
    wait_done(lat);
    chk("bp_latency", lat, 4);
    for (int k = 0; k < 5; k++) begin
      in_valid = (k == 1);
      a = 16'hAAAA; b = 16'h5555; mode = 1'b1;
      @(negedge clk);
      chk($sformatf("bp_hold_sum%0d", k), sum, 16'h3333);
      chk($sformatf("bp_hold_hs%0d", k), {out_valid, in_ready}, 2'b10);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_transfer", {out_valid, in_ready}, 2'b01);
    @(negedge clk);
    chk("bp_no_capture", {out_valid, in_ready}, 2'b01);
    chk("bp_sum_after", sum, 16'h3333);

    // Reset during the second CALC cycle discards the operation
    start_op(16'h0F0F, 16'h0101, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_hs", {out_valid, in_ready}, 2'b01);
    chk("mid_rst_sum", sum, 16'h0000);
    chk("mid_rst_flags", {carry_out, overflow, zero}, 3'b000);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("mid_rst_no_valid", seen, 0);
    start_op(16'h1234, 16'h0FFF, 1'b0);
    wait_done(lat);
    chk("post_rst_latency", lat, 4);
    chk("post_rst_sum", sum, 16'h2233);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/addsub_serial.md
Name: addsub_serial

Overview:
- Parametrised multi-cycle add/subtract unit: processes CHUNK bits per clock over WIDTH/CHUNK cycles, trading latency for a narrow carry chain.
- Carries operands and results over valid/ready handshakes on input and output.
- Adds overflow and zero flags, and optional signed saturation.
- Sits in the datapath wherever a WIDTH-bit add/sub is needed without a full-width combinational adder.

Parameters:
- WIDTH, 16, operand and result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits processed per clock; 1 <= CHUNK <= WIDTH.
- Derived NCHUNK = WIDTH/CHUNK, the number of CALC cycles.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  operands a, b, mode are valid.
- in_ready  output  1  unit can accept operands.
- a  input  WIDTH  first operand.
- b  input  WIDTH  second operand.
- mode  input  1  0 = a+b, 1 = a-b.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- carry_out  output  1  add: carry out of the MSB; sub: borrow (1 when unsigned a < b).
- overflow  output  1  signed two's-complement overflow.
- zero  output  1  sum == 0 (after saturation, if enabled).

Behaviour:
- Interface:
  - One clock domain.
  - Reset is synchronous and active-high on `reset`, sampled at the rising edge of `clk`.
- Reset:
  - state = IDLE, in_ready = 1, out_valid = 0.
  - sum = 0, carry_out = 0, overflow = 0, zero = 0.
  - Internal operand, carry and chunk-counter registers are cleared.
- FSM states: IDLE, CALC, DONE.
  - IDLE: in_ready = 1. On in_valid && in_ready at an edge, register a and b (b is inverted when mode = 1), register mode, set the carry register to mode, set chunk index to 0, go to CALC.
  - CALC: in_ready = 0. Each edge adds chunk[i] of a, chunk[i] of b' and the carry, writes the CHUNK result bits into sum[i], and updates the carry. After the edge processing chunk NCHUNK-1, compute the flags and go to DONE.
  - DONE: out_valid = 1. sum and flags are held stable while out_ready = 0. On out_valid && out_ready at an edge, go to IDLE with out_valid = 0.
- Latency:
  - Acceptance edge, then NCHUNK edges in CALC; out_valid rises after the NCHUNK-th CALC edge.
  - Minimum issue interval is NCHUNK+2 cycles.
- Arithmetic:
  - Subtraction computes a + ~b + 1 with the LSB carry-in = 1.
  - add: carry_out = final carry. sub: carry_out = ~final carry, i.e. {carry_out, sum} equals the (WIDTH+1)-bit zero-extended a-b.
  - overflow: add = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]); sub = (a[MSB] != b[MSB]) && (sum[MSB] != a[MSB]). Both are evaluated on the raw, unsaturated sum.
- Boundaries:
  - in_valid while not IDLE is ignored; operands are not captured.
  - Input a/b/mode changing after acceptance has no effect.
  - sum and flags outputs hold their previous values during CALC (a shadow register is used) and update on entry to DONE.
  - out_ready asserted outside DONE has no effect.
  - WIDTH == CHUNK gives a single CALC cycle.
  - Reset in any state returns to reset values at the next edge; any in-flight operation is discarded and no out_valid is produced for it.

Optional Feature:
- Macro ADDSUB_SAT_EN.
- Defined:
  - When overflow = 1, sum is clamped to signed limits: positive overflow gives 0111..1, negative overflow gives 1000..0.
  - overflow and carry_out still report raw conditions; zero reflects the clamped sum.
- Undefined: sum wraps modulo 2^WIDTH; no clamp logic is present.

Test Plan (WIDTH=16, CHUNK=4):
- Reset asserted 2 cycles -> in_ready=1, out_valid=0, sum=0x0000, all flags 0.
- add 0x1234+0x0FFF, out_ready=1 -> out_valid rises 4 edges after acceptance; sum=0x2233, carry_out=0, overflow=0, zero=0. Back to IDLE next edge.
- add 0xFFFF+0x0001 -> sum=0x0000, carry_out=1, zero=1, overflow=0. Then sub 0x0003-0x0005 -> sum=0xFFFE, carry_out=1, overflow=0.
- add 0x7FFF+0x0001 -> overflow=1, carry_out=0; sum=0x8000 without macro, 0x7FFF with ADDSUB_SAT_EN. sub 0x8000-0x0001 -> overflow=1; sum=0x7FFF without macro, 0x8000 with it.
- Backpressure: result ready, out_ready=0 for 5 cycles with a new in_valid pulse -> sum/flags stable, in_ready=0, new operands not captured. out_ready=1 -> one transfer, then IDLE.
- Reset asserted during the 2nd CALC cycle -> next edge shows reset values and IDLE. No out_valid follows; a fresh op afterwards gives a correct result.
